// File: rtl/aidc_core.sv
// AXI inline compressor: registered address remap, W delta-encode and R delta-decode.
// Optional beat counter enabled by defining AIDC_STATS_EN.
module aidc_core #(
    parameter int DATA_W     = 32,
    parameter int ADDR_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ENABLE_i,
    input  logic [DATA_W-1:0] icnt_aw_intf,
    input  logic [DATA_W-1:0] icnt_w_intf,
    output logic [DATA_W-1:0] icnt_b_intf,
    input  logic [DATA_W-1:0] icnt_ar_intf,
    output logic [DATA_W-1:0] icnt_r_intf,
    output logic [DATA_W-1:0] mc_aw_intf,
    output logic [DATA_W-1:0] mc_w_intf,
    input  logic [DATA_W-1:0] mc_b_intf,
    output logic [DATA_W-1:0] mc_ar_intf,
    input  logic [DATA_W-1:0] mc_r_intf
`ifdef AIDC_STATS_EN
   ,output logic [15:0]       comp_beat_cnt_o
`endif
);

    localparam int PW = DATA_W - 1;

    logic [PW-1:0]     r_w_prev;
    logic [PW-1:0]     r_r_prev;

    logic              w_aw_v, w_w_v, w_ar_v, w_r_v;
    logic [PW-1:0]     w_w_enc, w_r_dec;
    logic [DATA_W-1:0] w_aw_next, w_w_next, w_ar_next, w_r_next;

    assign w_aw_v  = icnt_aw_intf[DATA_W-1];
    assign w_w_v   = icnt_w_intf[DATA_W-1];
    assign w_ar_v  = icnt_ar_intf[DATA_W-1];
    assign w_r_v   = mc_r_intf[DATA_W-1];

    assign w_w_enc = icnt_w_intf[PW-1:0] ^ r_w_prev;
    assign w_r_dec = mc_r_intf[PW-1:0] ^ r_r_prev;

    // Invalid beats collapse to all-zero words; payload is never forwarded.
    assign w_aw_next = !w_aw_v ? '0 :
                       ENABLE_i ? {1'b1, icnt_aw_intf[PW-1:0] >> ADDR_SHIFT} : icnt_aw_intf;
    assign w_ar_next = !w_ar_v ? '0 :
                       ENABLE_i ? {1'b1, icnt_ar_intf[PW-1:0] >> ADDR_SHIFT} : icnt_ar_intf;
    assign w_w_next  = !w_w_v ? '0 : (ENABLE_i ? {1'b1, w_w_enc} : icnt_w_intf);
    assign w_r_next  = !w_r_v ? '0 : (ENABLE_i ? {1'b1, w_r_dec} : mc_r_intf);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            mc_aw_intf  <= '0;
            mc_w_intf   <= '0;
            mc_ar_intf  <= '0;
            icnt_r_intf <= '0;
            icnt_b_intf <= '0;
            r_w_prev    <= '0;
            r_r_prev    <= '0;
        end else begin
            mc_aw_intf  <= w_aw_next;
            mc_w_intf   <= w_w_next;
            mc_ar_intf  <= w_ar_next;
            icnt_r_intf <= w_r_next;
            icnt_b_intf <= mc_b_intf;
            // Histories track raw write data and decoded read data, so both ends agree.
            if (!ENABLE_i) begin
                r_w_prev <= '0;
                r_r_prev <= '0;
            end else begin
                if (w_w_v) r_w_prev <= icnt_w_intf[PW-1:0];
                if (w_r_v) r_r_prev <= w_r_dec;
            end
        end
    end

`ifdef AIDC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst_n)
            comp_beat_cnt_o <= '0;
        else if (ENABLE_i && w_w_v)
            comp_beat_cnt_o <= comp_beat_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_aidc_core.sv
module tb_aidc_core;

    logic        clk;
    logic        rst_n;
    logic        ENABLE_i;
    logic [31:0] icnt_aw_intf, icnt_w_intf, icnt_ar_intf, mc_b_intf, mc_r_intf;
    logic [31:0] icnt_b_intf, icnt_r_intf, mc_aw_intf, mc_w_intf, mc_ar_intf;
`ifdef AIDC_STATS_EN
    logic [15:0] comp_beat_cnt_o;
`endif

    aidc_core #(.DATA_W(32), .ADDR_SHIFT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ENABLE_i     (ENABLE_i),
        .icnt_aw_intf (icnt_aw_intf),
        .icnt_w_intf  (icnt_w_intf),
        .icnt_b_intf  (icnt_b_intf),
        .icnt_ar_intf (icnt_ar_intf),
        .icnt_r_intf  (icnt_r_intf),
        .mc_aw_intf   (mc_aw_intf),
        .mc_w_intf    (mc_w_intf),
        .mc_b_intf    (mc_b_intf),
        .mc_ar_intf   (mc_ar_intf),
        .mc_r_intf    (mc_r_intf)
`ifdef AIDC_STATS_EN
       ,.comp_beat_cnt_o (comp_beat_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        int          ch;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] act;

    localparam int CH_AW = 0, CH_W = 1, CH_AR = 2, CH_R = 3, CH_B = 4, CH_CNT = 5;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string chname(input int ch);
        case (ch)
            CH_AW:   return "mc_aw";
            CH_W:    return "mc_w";
            CH_AR:   return "mc_ar";
            CH_R:    return "icnt_r";
            CH_B:    return "icnt_b";
            default: return "beat_cnt";
        endcase
    endfunction

    function automatic logic [31:0] pick(input int ch);
        case (ch)
            CH_AW:   return mc_aw_intf;
            CH_W:    return mc_w_intf;
            CH_AR:   return mc_ar_intf;
            CH_R:    return icnt_r_intf;
            CH_B:    return icnt_b_intf;
`ifdef AIDC_STATS_EN
            CH_CNT:  return {16'h0, comp_beat_cnt_o};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = pick(e.ch);
            n_cmp++;
            if (e.cyc != cyc || act !== e.val) begin
                n_bad++;
                $display("FAIL %s @cyc %0d (due %0d): got %h expected %h",
                         chname(e.ch), cyc, e.cyc, act, e.val);
            end
        end
    end

    task automatic step(input logic rst, input logic en, input logic [31:0] aw, input logic [31:0] w,
                        input logic [31:0] ar, input logic [31:0] r, input logic [31:0] b);
        @(posedge clk);
        #1;
        rst_n        = rst;
        ENABLE_i     = en;
        icnt_aw_intf = aw;
        icnt_w_intf  = w;
        icnt_ar_intf = ar;
        mc_r_intf    = r;
        mc_b_intf    = b;
    endtask

    task automatic expect_out(input int ch, input logic [31:0] v);
        q.push_back('{cyc + 1, ch, v});
    endtask

    task automatic expect_cnt(input logic [15:0] v);
`ifdef AIDC_STATS_EN
        expect_out(CH_CNT, {16'h0, v});
`else
        if (v == 16'hFFFF) $display("unused");
`endif
    endtask

    initial begin
        rst_n = 1'b1; ENABLE_i = 1'b0;
        icnt_aw_intf = '0; icnt_w_intf = '0; icnt_ar_intf = '0; mc_r_intf = '0; mc_b_intf = '0;

        for (int i = 0; i < 3; i++) begin
            step(1, 1, '1, '1, '1, '1, '1);
            for (int c = CH_AW; c <= CH_B; c++) expect_out(c, 32'h0);
            expect_cnt(16'd0);
        end

        step(0, 0, 32'h8000_1000, 0, 0, 0, 0);
        expect_out(CH_AW, 32'h8000_1000);
        expect_out(CH_W, 32'h0);
        expect_out(CH_B, 32'h0);

        step(0, 1, 32'h8000_1000, 32'h8000_0005, 32'h8000_0003, 32'h8000_0005, 0);
        expect_out(CH_AW, 32'h8000_0800);
        expect_out(CH_AR, 32'h8000_0001);
        expect_out(CH_W, 32'h8000_0005);
        expect_out(CH_R, 32'h8000_0005);
        expect_cnt(16'd1);

        step(0, 1, 0, 32'h8000_0007, 0, 32'h8000_0002, 32'h8000_0001);
        expect_out(CH_AW, 32'h0);
        expect_out(CH_W, 32'h8000_0002);
        expect_out(CH_R, 32'h8000_0007);
        expect_out(CH_B, 32'h8000_0001);
        expect_cnt(16'd2);

        step(0, 1, 0, 32'h0000_1234, 0, 0, 0);
        expect_out(CH_W, 32'h0);
        expect_out(CH_R, 32'h0);
        expect_out(CH_B, 32'h0);
        expect_cnt(16'd2);

        step(0, 0, 0, 0, 0, 0, 32'h8000_0001);
        expect_out(CH_B, 32'h8000_0001);

        step(0, 1, 0, 32'h8000_0009, 0, 32'h8000_0009, 0);
        expect_out(CH_W, 32'h8000_0009);
        expect_out(CH_R, 32'h8000_0009);
        expect_cnt(16'd3);

        step(0, 1, 32'h0000_1000, 32'h8000_0003, 0, 32'h8000_000A, 0);
        expect_out(CH_AW, 32'h0);
        expect_out(CH_W, 32'h8000_000A);
        expect_out(CH_R, 32'h8000_0003);
        expect_cnt(16'd4);

        step(0, 0, 32'hFFFF_FFFE, 32'h8000_0003, 32'h7FFF_FFFF, 0, 0);
        expect_out(CH_AW, 32'hFFFF_FFFE);
        expect_out(CH_W, 32'h8000_0003);
        expect_out(CH_AR, 32'h0);
        expect_cnt(16'd4);

        step(0, 1, 32'hFFFF_FFFF, 32'h8000_0004, 0, 0, 0);
        expect_out(CH_AW, 32'hBFFF_FFFF);
        expect_out(CH_W, 32'h8000_0004);
        expect_cnt(16'd5);

        step(1, 1, 32'h8000_1000, 32'h8000_0011, 32'h8000_0003, 32'h8000_0011, 32'h8000_0001);
        for (int c = CH_AW; c <= CH_B; c++) expect_out(c, 32'h0);
        expect_cnt(16'd0);

        step(0, 1, 0, 32'h8000_0006, 0, 32'h8000_0002, 0);
        expect_out(CH_W, 32'h8000_0006);
        expect_out(CH_R, 32'h8000_0002);
        expect_cnt(16'd1);

        step(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (mc_w_intf !== 32'h8000_0006) begin
            n_bad++;
            $display("FAIL direct mc_w: got %h expected 80000006", mc_w_intf);
        end
        n_cmp++;
        if (icnt_r_intf !== 32'h8000_0002) begin
            n_bad++;
            $display("FAIL direct icnt_r: got %h expected 80000002", icnt_r_intf);
        end
        n_cmp++;
        if (mc_aw_intf !== 32'h0) begin
            n_bad++;
            $display("FAIL direct mc_aw: got %h expected 00000000", mc_aw_intf);
        end
        n_cmp++;
        if (icnt_b_intf !== 32'h0) begin
            n_bad++;
            $display("FAIL direct icnt_b: got %h expected 00000000", icnt_b_intf);
        end
`ifdef AIDC_STATS_EN
        n_cmp++;
        if (comp_beat_cnt_o !== 16'd1) begin
            n_bad++;
            $display("FAIL direct beat_cnt: got %h expected 0001", comp_beat_cnt_o);
        end
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked, expected %h at cyc %0d", chname(e.ch), e.val, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
